spi_dbg_ctrl: RTL



---
 rtl/dbg_pkg.sv | 27 ++
 rtl/dbg_reply_shifter.sv | 35 +++
 rtl/spi_dbg_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/dbg_pkg.sv
// rtl/dbg_pkg.sv - command codes, FSM states and reply buffer sizing for spi_dbg_ctrl
package dbg_pkg;

  localparam logic [7:0] CMD_NOP        = 8'h00;
  localparam logic [7:0] CMD_ECHO       = 8'h01;
  localparam logic [7:0] CMD_LED_TOGGLE = 8'h02;
  localparam logic [7:0] CMD_CLK_RUN    = 8'h03;
  localparam logic [7:0] CMD_CLK_HALT   = 8'h04;
  localparam logic [7:0] CMD_CLK_STEP   = 8'h05;
  localparam logic [7:0] CMD_READ_PC    = 8'h06;
  localparam logic [7:0] CMD_READ_REG   = 8'h07;
  localparam logic [7:0] CMD_FLASH_BUSY = 8'h08;
  localparam logic [7:0] CMD_READ_FETCH = 8'h09;
  localparam logic [7:0] CMD_PING       = 8'hCC;

  localparam int BUF_W = 128;
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ECHO,
    ST_READ_REG,
    ST_REG_CAPTURE,
    ST_REPLYING
  } state_t;

endpackage

// File: rtl/dbg_reply_shifter.sv
// rtl/dbg_reply_shifter.sv - multi-byte reply buffer, emits bytes MSB first
module dbg_reply_shifter
  import dbg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [BUF_W-1:0] load_data,
  input  logic [CNT_W-1:0] load_count,
  input  logic             shift,
  output logic [7:0]       cur_byte,
  output logic             last
);

  logic [BUF_W-1:0] buffer;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      buffer <= '0;
      count  <= '0;
    end else if (load) begin
      buffer <= load_data;
      count  <= load_count;
    end else if (shift && count != '0) begin
      count <= count - 1'b1;
    end
  end

  // Byte index count-1 selects the next unsent byte, highest first.
  assign cur_byte = buffer[{count - 4'd1, 3'b000} +: 8];
  assign last     = (count == 4'd1);

endmodule

// File: rtl/spi_dbg_ctrl.sv
// rtl/spi_dbg_ctrl.sv - SPI debug command decoder: core clock control, readback replies
module spi_dbg_ctrl
  import dbg_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int FETCH_W = 112
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               recv_ready,
  input  logic [7:0]         recv_data,
  input  logic               frame_end,
  output logic [7:0]         send_data,
  output logic               core_clk_enable,
  output logic               core_clk_pulse,
  output logic               led_toggle,
  output logic [4:0]         reg_read_sel,
  input  logic [XLEN-1:0]    reg_read_data,
  input  logic [XLEN-1:0]    reg_pc,
  input  logic [FETCH_W-1:0] fetch_instr
);

  state_t           state, state_next;
  logic [7:0]       send_next;
  logic             en_next, pulse_next, led_next;
  logic [4:0]       sel_next;
  logic             sh_clear, sh_load, sh_shift, sh_last;
  logic [BUF_W-1:0] sh_data;
  logic [CNT_W-1:0] sh_count;
  logic [7:0]       sh_byte;

  dbg_reply_shifter u_shifter (
    .clk        (clk),
    .rst        (rst),
    .clear      (sh_clear),
    .load       (sh_load),
    .load_data  (sh_data),
    .load_count (sh_count),
    .shift      (sh_shift),
    .cur_byte   (sh_byte),
    .last       (sh_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      send_data       <= 8'h00;
      core_clk_enable <= 1'b1;
      core_clk_pulse  <= 1'b0;
      led_toggle      <= 1'b0;
      reg_read_sel    <= 5'd0;
    end else begin
      state           <= state_next;
      send_data       <= send_next;
      core_clk_enable <= en_next;
      core_clk_pulse  <= pulse_next;
      led_toggle      <= led_next;
      reg_read_sel    <= sel_next;
    end
  end

  always_comb begin
    state_next = state;
    send_next  = send_data;
    en_next    = core_clk_enable;
    pulse_next = core_clk_pulse;
    led_next   = led_toggle;
    sel_next   = reg_read_sel;
    sh_clear   = 1'b0;
    sh_load    = 1'b0;
    sh_shift   = 1'b0;
    sh_data    = '0;
    sh_count   = '0;

    case (state)
      ST_IDLE: begin
        if (recv_ready) begin
          send_next = 8'h00;
          case (recv_data)
            CMD_NOP:        ;
            CMD_ECHO:       begin send_next = 8'h01; state_next = ST_ECHO; end
            CMD_LED_TOGGLE: led_next = ~led_toggle;
            CMD_CLK_RUN:    en_next = 1'b1;
            CMD_CLK_HALT:   en_next = 1'b0;
            CMD_CLK_STEP:   pulse_next = ~core_clk_pulse;
            CMD_READ_PC: begin
              sh_load    = 1'b1;
              sh_data    = BUF_W'(reg_pc);
              sh_count   = 4'd8;
              state_next = ST_REPLYING;
            end
            CMD_READ_REG:   state_next = ST_READ_REG;
            CMD_FLASH_BUSY: send_next = 8'hFF;
            CMD_READ_FETCH: begin
              sh_load    = 1'b1;
              sh_data    = BUF_W'(fetch_instr);
              sh_count   = 4'd14;
              state_next = ST_REPLYING;
            end
            CMD_PING:       send_next = 8'hCC;
            default:        send_next = 8'hFF;
          endcase
        end
      end
      ST_ECHO: begin
        if (recv_ready) begin
          send_next  = recv_data;
          state_next = ST_IDLE;
        end
      end
      ST_READ_REG: begin
        if (recv_ready) begin
          sel_next   = recv_data[4:0];
          send_next  = 8'h00;
          state_next = ST_REG_CAPTURE;
        end
      end
      ST_REG_CAPTURE: begin
        // reg_read_sel was registered last cycle, so reg_read_data is now valid.
        sh_load    = 1'b1;
        sh_data    = BUF_W'(reg_read_data);
        sh_count   = 4'd8;
        state_next = ST_REPLYING;
      end
      ST_REPLYING: begin
        if (recv_ready) begin
          send_next = sh_byte;
          sh_shift  = 1'b1;
          if (sh_last) state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // End of frame aborts any transaction; clock/LED side effects above still stand.
    if (frame_end) begin
      state_next = ST_IDLE;
      send_next  = 8'h00;
      sel_next   = reg_read_sel;
      sh_clear   = 1'b1;
      sh_load    = 1'b0;
      sh_shift   = 1'b0;
    end
  end

endmodule
